// File: rtl/neuron_config_writer_pkg.sv
// Shared opcodes, FSM state type and parameter-word layout helpers for the
// neuron configuration writer.
package neuron_config_writer_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_CLEAR   = 8'h02;
  localparam logic [7:0] CMD_DISABLE = 8'h03;
  localparam logic [7:0] CMD_ENABLE  = 8'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic int unsigned cfg_width(input int unsigned m);
    return 6 * m + 6;
  endfunction

  function automatic int unsigned cfg_bytes(input int unsigned m);
    return (cfg_width(m) + 7) / 8;
  endfunction

  // Word is packed LSB-first: weights, delay_values, delays, threshold, decay, refractory
  function automatic int unsigned off_delay_values(input int unsigned m);
    return 2 * m;
  endfunction

  function automatic int unsigned off_delays(input int unsigned m);
    return 5 * m;
  endfunction

  function automatic int unsigned off_threshold(input int unsigned m);
    return 6 * m;
  endfunction

  function automatic int unsigned off_decay(input int unsigned m);
    return 6 * m + 2;
  endfunction

  function automatic int unsigned off_refractory(input int unsigned m);
    return 6 * m + 4;
  endfunction

endpackage

// File: rtl/neuron_config_writer_shadow.sv
// Byte-addressed shadow register with its byte counter; load_done flags the
// acceptance of the final data byte of a frame.
module cfg_shadow_reg
  import neuron_config_writer_pkg::*;
#(
  parameter int unsigned M = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    wr_en,
  input  logic [7:0]              data,
  output logic [cfg_width(M)-1:0] shadow,
  output logic                    load_done
);

  localparam int unsigned W  = cfg_width(M);
  localparam int unsigned NB = cfg_bytes(M);
  localparam int unsigned CW = $clog2(NB + 1);

  logic [CW-1:0] cnt;

  assign load_done = wr_en && (cnt == CW'(NB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (wr_en) begin
      cnt <= cnt + CW'(1);
      // Bits of the last byte that fall beyond W-1 simply have no destination
      for (int unsigned i = 0; i < W; i++) begin
        if ((i / 8) == int'(cnt)) shadow[i] <= data[i % 8];
      end
    end
  end

endmodule

// File: rtl/neuron_config_writer.sv
// Byte-serial configuration writer: assembles a parameter word in a shadow
// register and commits it atomically to the neuron's parameter buses.
module neuron_config_writer
  import neuron_config_writer_pkg::*;
#(
  parameter int unsigned M = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*M-1:0] weights,
  output logic [3*M-1:0] delay_values,
  output logic [M-1:0]   delays,
  output logic [1:0]     threshold,
  output logic [1:0]     decay,
  output logic [1:0]     refractory_period,
  output logic           neuron_enable,
  output logic           cfg_update,
  output logic           cmd_err
);

  localparam int unsigned W = cfg_width(M);

  state_t         state;
  logic [W-1:0]   active;
  logic [W-1:0]   shadow;
  logic           committed;
  logic           accept;
  logic           start;
  logic           load_wr;
  logic           load_done;

  assign in_ready = (state != COMMIT);
  assign accept   = in_valid && in_ready;
  assign start    = accept && (state == IDLE) && (in_data == CMD_WRITE);
  assign load_wr  = accept && (state == LOAD);

  cfg_shadow_reg #(.M(M)) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wr_en    (load_wr),
    .data     (in_data),
    .shadow   (shadow),
    .load_done(load_done)
  );

  assign weights           = active[2*M-1:0];
  assign delay_values      = active[off_delay_values(M) +: 3*M];
  assign delays            = active[off_delays(M) +: M];
  assign threshold         = active[off_threshold(M) +: 2];
  assign decay             = active[off_decay(M) +: 2];
  assign refractory_period = active[off_refractory(M) +: 2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      active        <= '0;
      committed     <= 1'b0;
      neuron_enable <= 1'b0;
      cfg_update    <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      cmd_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (in_data)
              CMD_WRITE:   state <= LOAD;
              CMD_CLEAR: begin
                active        <= '0;
                neuron_enable <= 1'b0;
                committed     <= 1'b0;
                cfg_update    <= 1'b1;
              end
              CMD_DISABLE: neuron_enable <= 1'b0;
              CMD_ENABLE:  if (committed) neuron_enable <= 1'b1;
              default:     cmd_err <= 1'b1;
            endcase
          end
        end
        LOAD: begin
          if (load_done) state <= COMMIT;
        end
        COMMIT: begin
          active        <= shadow;
          neuron_enable <= 1'b1;
          committed     <= 1'b1;
          cfg_update    <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_config_writer.sv
// Self-checking bench for neuron_config_writer (M=2) against a byte-level
// behavioural model of the command stream.
module tb_neuron_config_writer;

  localparam int M  = 2;
  localparam int W  = 6 * M + 6;
  localparam int NB = (W + 7) / 8;

  logic           clk;
  logic           rst_n;
  logic [7:0]     in_data;
  logic           in_valid;
  logic           in_ready;
  logic [2*M-1:0] weights;
  logic [3*M-1:0] delay_values;
  logic [M-1:0]   delays;
  logic [1:0]     threshold;
  logic [1:0]     decay;
  logic [1:0]     refractory_period;
  logic           neuron_enable;
  logic           cfg_update;
  logic           cmd_err;

  neuron_config_writer #(.M(M)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .weights          (weights),
    .delay_values     (delay_values),
    .delays           (delays),
    .threshold        (threshold),
    .decay            (decay),
    .refractory_period(refractory_period),
    .neuron_enable    (neuron_enable),
    .cfg_update       (cfg_update),
    .cmd_err          (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [W-1:0]    m_word;
  logic [8*NB-1:0] m_shadow;
  logic            m_en, m_committed, m_load, m_pending;
  int              m_cnt;
  int              exp_upd = 0, exp_err = 0;
  int              upd_seen = 0, err_seen = 0;
  int              waits = 0;

  always @(posedge clk) begin
    if (cfg_update) upd_seen++;
    if (cmd_err)    err_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_word = '0; m_shadow = '0; m_en = 0; m_committed = 0;
    m_load = 0; m_pending = 0; m_cnt = 0;
  endtask

  task automatic model_apply_commit();
    if (m_pending) begin
      m_word      = m_shadow[W-1:0];
      m_en        = 1;
      m_committed = 1;
      m_pending   = 0;
      exp_upd++;
    end
  endtask

  task automatic model_accept(input logic [7:0] b);
    model_apply_commit();
    if (m_load) begin
      m_shadow[8*m_cnt +: 8] = b;
      m_cnt++;
      if (m_cnt == NB) begin
        m_load    = 0;
        m_pending = 1;
      end
    end else begin
      case (b)
        8'h01: begin m_load = 1; m_cnt = 0; end
        8'h02: begin m_word = '0; m_en = 0; m_committed = 0; exp_upd++; end
        8'h03: m_en = 0;
        8'h04: if (m_committed) m_en = 1;
        default: exp_err++;
      endcase
    end
  endtask

  // Present a byte; in_valid is left high so consecutive calls stream back-to-back
  task automatic send_byte(input logic [7:0] b);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
      waits++;
    end
    if (guard >= 10) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    model_accept(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (i == 1) model_apply_commit();
    end
  endtask

  task automatic check_params(input string tag);
    logic [W-1:0] w;
    w = m_word;
    chk({tag, ".weights"},   32'(weights),           32'(w[2*M-1:0]));
    chk({tag, ".dval"},      32'(delay_values),      32'(w[2*M +: 3*M]));
    chk({tag, ".delays"},    32'(delays),            32'(w[5*M +: M]));
    chk({tag, ".threshold"}, 32'(threshold),         32'(w[6*M +: 2]));
    chk({tag, ".decay"},     32'(decay),             32'(w[6*M+2 +: 2]));
    chk({tag, ".refr"},      32'(refractory_period), 32'(w[6*M+4 +: 2]));
    chk({tag, ".enable"},    32'(neuron_enable),     32'(m_en));
  endtask

  task automatic check_all(input string tag);
    check_params(tag);
    chk({tag, ".upd_cnt"}, 32'(upd_seen), 32'(exp_upd));
    chk({tag, ".err_cnt"}, 32'(err_seen), 32'(exp_err));
    chk({tag, ".ready"},   32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #3;
    check_params("reset_async");
    chk("reset.cfg_update", 32'(cfg_update), 32'd0);
    chk("reset.cmd_err",    32'(cmd_err),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [8*NB-1:0] data, input int max_stall);
    send_byte(8'h01);
    for (int k = 0; k < NB; k++) begin
      if (max_stall > 0) begin
        int s;
        s = $urandom_range(max_stall, 0);
        if (s > 0) idle(s);
      end
      send_byte(data[8*k +: 8]);
    end
  endtask

  initial begin
    logic [8*NB-1:0] f;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_reset();
    #1;
    do_reset();
    idle(2);
    check_all("post_reset");

    // ENABLE with nothing committed is ignored
    send_byte(8'h04);
    idle(3);
    check_all("enable_no_commit");

    // Directed frame with commit timing
    send_byte(8'h01);
    send_byte(8'hB4);
    send_byte(8'h3E);
    send_byte(8'h02);
    @(negedge clk);
    in_valid = 1'b0;
    chk("commit.ready_low",  32'(in_ready),   32'd0);
    chk("commit.upd_early",  32'(cfg_update), 32'd0);
    chk("commit.old_weights", 32'(weights),   32'd0);
    @(negedge clk);
    chk("commit.upd_pulse",  32'(cfg_update), 32'd1);
    model_apply_commit();
    check_params("commit");
    chk("commit.weights_k",  32'(weights),           32'h4);
    chk("commit.dval_k",     32'(delay_values),      32'h2B);
    chk("commit.delays_k",   32'(delays),            32'h3);
    chk("commit.refr_k",     32'(refractory_period), 32'h2);
    @(negedge clk);
    chk("commit.upd_fall",   32'(cfg_update), 32'd0);
    idle(2);
    check_all("frame1");

    // Back-to-back frames, in_valid held high throughout
    waits = 0;
    send_frame(24'h15A7C3, 0);
    send_frame(24'h03E21D, 0);
    chk("b2b.ready_gaps", 32'(waits), 32'd1);
    idle(3);
    check_all("b2b");

    // Mid-load stall: outputs hold old values
    send_byte(8'h01);
    send_byte(8'h5A);
    idle(5);
    check_params("stall_hold");
    send_byte(8'h02);
    send_byte(8'h01);
    idle(3);
    check_all("stall_done");

    // DISABLE / ENABLE and CLEAR in IDLE
    send_byte(8'h03);
    idle(3);
    check_all("disable");
    send_byte(8'h04);
    idle(3);
    check_all("enable");
    send_byte(8'hFF);
    idle(3);
    check_all("bad_cmd");
    send_byte(8'h02);
    idle(3);
    check_all("clear");
    send_byte(8'h04);
    idle(3);
    check_all("enable_after_clear");

    // Reset in the middle of a load, then a clean frame
    send_frame(24'h2C9E71, 0);
    idle(3);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'h55);
    do_reset();
    idle(2);
    check_all("mid_load_reset");
    send_frame(24'h01F0E6, 2);
    idle(3);
    check_all("after_reset_frame");

    // Random streams: frames with stalls, commands and arbitrary bytes
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(3, 0))
        0, 1: begin
          f = 24'($urandom);
          send_frame(f, 3);
        end
        2: send_byte(8'($urandom_range(5, 1)));
        default: send_byte(8'($urandom));
      endcase
      if (!m_load) begin
        idle(3);
        check_all("rand");
      end
    end
    while (m_load) send_byte(8'($urandom));
    idle(3);
    check_all("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
